// File: rtl/gift_pkg.sv
// GIFT cipher primitives shared by the iterative core: S-box, bit permutation,
// round-key/constant injection and the key-schedule step.
package gift_pkg;

  localparam int unsigned STATE_W = 128;
  localparam int unsigned KEY_W   = 128;
  localparam int unsigned RC_W    = 6;

  // Nibble n of this word is S(n).
  localparam logic [63:0] SBOX = 64'hE805_7BD2_93F6_C4A1;

  typedef logic [STATE_W-1:0] state_t;
  typedef logic [KEY_W-1:0]   key_t;
  typedef logic [RC_W-1:0]    rc_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } fsm_e;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    return SBOX[{x, 2'b00} +: 4];
  endfunction

  function automatic state_t sub_cells(input state_t s);
    state_t r;
    for (int unsigned n = 0; n < STATE_W / 4; n++) begin
      r[7'(4 * n) +: 4] = sbox(s[7'(4 * n) +: 4]);
    end
    return r;
  endfunction

  function automatic state_t perm_bits(input state_t s, input int unsigned width);
    state_t      r;
    int unsigned d;
    r = '0;
    for (int unsigned i = 0; i < STATE_W; i++) begin
      if (i < width) begin
        d = 4 * (i / 16) + (width / 4) * ((3 * ((i % 16) / 4) + i % 4) % 4) + i % 4;
        r[7'(d)] = s[7'(i)];
      end
    end
    return r;
  endfunction

  // 64-bit blocks take U=k1,V=k0 on bits 1/0; 128-bit take U=k5||k4,V=k1||k0 on bits 2/1.
  function automatic state_t add_round_key(input state_t s, input key_t k, input int unsigned width);
    state_t r;
    r = s;
    if (width == 64) begin
      for (int unsigned i = 0; i < 16; i++) begin
        r[7'(4 * i + 1)] = r[7'(4 * i + 1)] ^ k[7'(16 + i)];
        r[7'(4 * i)]     = r[7'(4 * i)]     ^ k[7'(i)];
      end
    end else begin
      for (int unsigned i = 0; i < 32; i++) begin
        r[7'(4 * i + 2)] = r[7'(4 * i + 2)] ^ k[7'(64 + i)];
        r[7'(4 * i + 1)] = r[7'(4 * i + 1)] ^ k[7'(i)];
      end
    end
    return r;
  endfunction

  function automatic state_t add_constant(input state_t s, input rc_t rc, input int unsigned width);
    state_t r;
    r = s;
    r[23] = r[23] ^ rc[5];
    r[19] = r[19] ^ rc[4];
    r[15] = r[15] ^ rc[3];
    r[11] = r[11] ^ rc[2];
    r[7]  = r[7]  ^ rc[1];
    r[3]  = r[3]  ^ rc[0];
    r[7'(width - 1)] = ~r[7'(width - 1)];
    return r;
  endfunction

  // K <= (k1 >>> 2) || (k0 >>> 12) || k7..k2
  function automatic key_t key_update(input key_t k);
    return {k[17:16], k[31:18], k[11:0], k[15:12], k[127:32]};
  endfunction

  function automatic rc_t rc_step(input rc_t rc);
    return {rc[4:0], rc[5] ^ rc[4] ^ 1'b1};
  endfunction

endpackage

// File: rtl/gift_iter_core_round.sv
// One combinational GIFT round: SubCells, PermBits, AddRoundKey, AddConstant.
module gift_iter_core_round
  import gift_pkg::*;
#(
  parameter int unsigned BLOCK_W = 64
) (
  input  logic [BLOCK_W-1:0] i_state,
  input  key_t               i_key,
  input  rc_t                i_rc,
  output logic [BLOCK_W-1:0] o_state_c
);

  state_t w_in;
  state_t w_sc;
  state_t w_pb;
  state_t w_ak;
  state_t w_next;

  assign w_in      = STATE_W'(i_state);
  assign w_sc      = sub_cells(w_in);
  assign w_pb      = perm_bits(w_sc, BLOCK_W);
  assign w_ak      = add_round_key(w_pb, i_key, BLOCK_W);
  assign w_next    = add_constant(w_ak, i_rc, BLOCK_W);
  assign o_state_c = w_next[BLOCK_W-1:0];

  // Narrow blocks leave the upper state lanes untouched and unused.
  generate
    if (BLOCK_W < STATE_W) begin : g_pad
      logic w_unused;
      assign w_unused = ^w_next[STATE_W-1:BLOCK_W];
    end
  endgenerate

endmodule

// File: rtl/gift_iter_core.sv
// Iterative GIFT-64/128 encryptor, one round per clock, valid/ready on both sides.
// Optional GIFT_KEY_REUSE_EN adds in_key_reuse and a stored master key.
module gift_iter_core
  import gift_pkg::*;
#(
  parameter int unsigned BLOCK_W    = 64,
  parameter int unsigned NUM_ROUNDS = 28
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [BLOCK_W-1:0] in_block,
  input  logic [KEY_W-1:0]   in_key,
`ifdef GIFT_KEY_REUSE_EN
  input  logic               in_key_reuse,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BLOCK_W-1:0] out_block,
  output logic               busy
);

  localparam int unsigned      RND_W    = $clog2(NUM_ROUNDS + 1);
  localparam logic [RND_W-1:0] LAST_RND = RND_W'(NUM_ROUNDS - 1);

  generate
    if (!(BLOCK_W == 64 || BLOCK_W == 128)) begin : g_bad_block_w
      $error("gift_iter_core: BLOCK_W must be 64 or 128");
    end
    if (NUM_ROUNDS < 1 || NUM_ROUNDS > 48) begin : g_bad_rounds
      $error("gift_iter_core: NUM_ROUNDS must be in 1..48");
    end
  endgenerate

  fsm_e               r_fsm;
  logic [BLOCK_W-1:0] r_state;
  key_t               r_key;
  rc_t                r_rc;
  logic [RND_W-1:0]   r_rnd;
  logic               r_in_ready;
  logic               r_out_valid;
  logic               r_busy;

  fsm_e               w_fsm_nxt;
  logic [BLOCK_W-1:0] w_state_nxt;
  key_t               w_key_nxt;
  rc_t                w_rc_nxt;
  logic [RND_W-1:0]   w_rnd_nxt;
  logic               w_accept;
  rc_t                w_rc_step;
  key_t               w_load_key;
  logic [BLOCK_W-1:0] w_round_state;

  assign w_rc_step = rc_step(r_rc);

  gift_iter_core_round #(
    .BLOCK_W (BLOCK_W)
  ) u_round (
    .i_state   (r_state),
    .i_key     (r_key),
    .i_rc      (w_rc_step),
    .o_state_c (w_round_state)
  );

`ifdef GIFT_KEY_REUSE_EN
  key_t r_master_key;

  assign w_load_key = in_key_reuse ? r_master_key : in_key;

  // Master key follows every fresh-key accept; reuse accepts leave it alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_master_key <= '0;
    end else if (w_accept && !in_key_reuse) begin
      r_master_key <= in_key;
    end
  end
`else
  assign w_load_key = in_key;
`endif

  // Next-state and datapath select.
  always_comb begin
    w_fsm_nxt   = r_fsm;
    w_state_nxt = r_state;
    w_key_nxt   = r_key;
    w_rc_nxt    = r_rc;
    w_rnd_nxt   = r_rnd;
    w_accept    = 1'b0;
    unique case (r_fsm)
      ST_IDLE: begin
        if (in_valid) begin
          w_accept    = 1'b1;
          w_fsm_nxt   = ST_RUN;
          w_state_nxt = in_block;
          w_key_nxt   = w_load_key;
          w_rc_nxt    = '0;
          w_rnd_nxt   = '0;
        end
      end
      ST_RUN: begin
        w_state_nxt = w_round_state;
        w_key_nxt   = key_update(r_key);
        w_rc_nxt    = w_rc_step;
        w_rnd_nxt   = r_rnd + 1'b1;
        if (r_rnd == LAST_RND) begin
          w_fsm_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          w_fsm_nxt = ST_IDLE;
        end
      end
      default: begin
        w_fsm_nxt = ST_IDLE;
      end
    endcase
  end

  // Handshake flags are registered from the next state so they track r_fsm exactly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fsm       <= ST_IDLE;
      r_state     <= '0;
      r_key       <= '0;
      r_rc        <= '0;
      r_rnd       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_fsm       <= w_fsm_nxt;
      r_state     <= w_state_nxt;
      r_key       <= w_key_nxt;
      r_rc        <= w_rc_nxt;
      r_rnd       <= w_rnd_nxt;
      r_in_ready  <= (w_fsm_nxt == ST_IDLE);
      r_out_valid <= (w_fsm_nxt == ST_DONE);
      r_busy      <= (w_fsm_nxt != ST_IDLE);
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign out_block = r_state;

endmodule
